fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
//  Parametrised program-counter and fetch-request generator for the RISC-V core front end.
//  Holds the fetch PC and issues it to instruction memory over a valid/ready handshake.
//  Advances by 4, or by 2 for compressed instructions; applies relative/absolute jumps and trap redirects.
//  Supports halt/resume and flags misaligned jump targets.
// PARAMETERS
//  PC_WIDTH      32     width of all address ports and the PC register
//  RESET_VECTOR  32'h0  PC value loaded at reset (must be 4-byte aligned)
//  COMPRESSED    0      1: enable RVC, step of 2 allowed, 2-byte alignment; 0: 4-byte only
// PORTS
//  clk              in   1         clock, rising edge
//  rst              in   1         asynchronous, active-low reset
//  fetch_valid      out  1         fetch_addr is a valid request
//  fetch_ready      in   1         memory accepts request this cycle
//  fetch_addr       out  PC_WIDTH  address being requested (= PC register)
//  fetch_compressed in   1         accepted instr is 16-bit; ignored if COMPRESSED=0
//  jump             in   1         one-cycle redirect request
//  not_relative_pc  in   1         1: target = jump_address; 0: target = PC + jump_address
//  jump_address     in   PC_WIDTH  absolute target or signed offset
//  trap             in   1         one-cycle trap redirect
//  trap_vector      in   PC_WIDTH  trap target; low 2 bits forced to 0
//  halt_req         in   1         level: request fetch halt
//  halted           out  1         unit in HALT state
//  misaligned_fault out  1         one-cycle pulse: jump target misaligned
// BEHAVIOUR
//  Reset (rst=0, async): PC=RESET_VECTOR, state=BOOT.
//   fetch_valid=0, halted=0, misaligned_fault=0.
//  FSM states:
//   BOOT: fetch_valid=0 for exactly 1 cycle after reset release -> RUN.
//    If halt_req=1, go to HALT instead.
//   RUN: fetch_valid=1.
//   HALT: fetch_valid=0, halted=1. halt_req=0 -> RUN next cycle.
//  Handshake: accept = fetch_valid & fetch_ready.
//   While fetch_valid=1 & fetch_ready=0, fetch_addr holds stable.
//   A redirect (trap/jump) may change fetch_addr as a flush.
//  Halt entry from RUN:
//   Only on an accept cycle or a redirect cycle; never drop an unaccepted request otherwise.
//   halt_req pending with no accept -> stay RUN.
//  Next-PC priority, highest first, evaluated every cycle in every state except BOOT:
//   1. trap: PC <= {trap_vector[W-1:2],2'b00}.
//   2. jump: T = (not_relative_pc ? 0 : PC) + jump_address, modulo 2^PC_WIDTH.
//      Misaligned = T[1:0]!=0 (COMPRESSED=0) or T[0]!=0 (COMPRESSED=1).
//      Misaligned -> PC <= aligned trap_vector; misaligned_fault=1 next cycle.
//      Aligned -> PC <= T.
//   3. accept: PC <= PC + ((COMPRESSED & fetch_compressed) ? 2 : 4), wraps modulo 2^PC_WIDTH.
//   4. else PC holds.
//  A redirect in the same cycle as an accept discards the increment; the accepted fetch still completes.
//  Redirects in HALT update PC; the unit stays in HALT.
//  Latency: a redirect or increment appears on fetch_addr the cycle after it is sampled.
//  misaligned_fault is registered and high for exactly one cycle per fault.
//  Reset mid-handshake aborts immediately: fetch_valid=0 asynchronously, PC=RESET_VECTOR.
// TESTING
//  1. Reset release, fetch_ready=1 tied, RESET_VECTOR=0.
//     -> valid low 1 cycle, then fetch_addr 0,4,8,C on successive cycles.
//  2. fetch_ready=0 for 3 cycles at PC=8.
//     -> fetch_addr=8, valid=1 stable throughout; PC=C after ready.
//  3. PC=0x10, jump=1, not_relative=0, jump_address=-8 with accept.
//     -> next fetch_addr=0x08; no increment applied.
//  4. jump=1, not_relative=1, jump_address=0x102, COMPRESSED=0, trap_vector=0x200.
//     -> fault pulse 1 cycle, fetch_addr=0x200.
//     COMPRESSED=1 -> fetch_addr=0x102, no fault.
//  5. trap and jump same cycle, trap_vector=0x303.
//     -> fetch_addr=0x300.
//     PC=0xFFFF_FFFC accept -> wraps to 0x0.
//  6. halt_req=1 while fetch_ready=0.
//     -> stays RUN until accept, then halted=1, valid=0.
//     halt_req=0 -> valid=1 next cycle at PC+4.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Fetch request bus between the PC unit (master) and instruction memory (slave).
interface fetch_pc_unit_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                fetch_valid;
  logic                fetch_ready;
  logic [PC_WIDTH-1:0] fetch_addr;
  logic                fetch_compressed;

  modport master (
    output fetch_valid,
    output fetch_addr,
    input  fetch_ready,
    input  fetch_compressed
  );

  modport slave (
    input  fetch_valid,
    input  fetch_addr,
    output fetch_ready,
    output fetch_compressed
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch-request generator: sequential step, jump/trap redirect,
// halt/resume and misaligned-target detection.
module fetch_pc_unit #(
  parameter int unsigned           PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter bit                    COMPRESSED   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_pc_unit_if.master     bus,
  input  logic                jump,
  input  logic                not_relative_pc,
  input  logic [PC_WIDTH-1:0] jump_address,
  input  logic                trap,
  input  logic [PC_WIDTH-1:0] trap_vector,
  input  logic                halt_req,
  output logic                halted,
  output logic                misaligned_fault
);

  localparam logic [PC_WIDTH-1:0] STEP_FULL  = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] STEP_HALF  = PC_WIDTH'(2);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                fault_q, fault_d;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] trap_aligned;
  logic [PC_WIDTH-1:0] step;
  logic                misaligned;
  logic                accept;
  logic                redirect;
  logic                valid;
  logic                halt_state;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_BOOT;
    else      state_q <= state_d;
  end

  assign accept   = (state_q == ST_RUN) && bus.fetch_ready;
  assign redirect = trap || jump;

  // Next state: leaving RUN only once the outstanding request is accepted or flushed
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = halt_req ? ST_HALT : ST_RUN;
      ST_RUN:  if (halt_req && (accept || redirect)) state_d = ST_HALT;
      ST_HALT: if (!halt_req) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    valid      = 1'b0;
    halt_state = 1'b0;
    case (state_q)
      ST_RUN:  valid      = 1'b1;
      ST_HALT: halt_state = 1'b1;
      default: ;
    endcase
  end

  assign bus.fetch_valid = valid;
  assign bus.fetch_addr  = pc_q;
  assign halted          = halt_state;

  assign trap_aligned = trap_vector & ALIGN_MASK;
  assign target       = (not_relative_pc ? '0 : pc_q) + jump_address;
  assign misaligned   = COMPRESSED ? target[0] : (target[1:0] != 2'b00);
  assign step         = (COMPRESSED && bus.fetch_compressed) ? STEP_HALF : STEP_FULL;

  // Next PC: trap > jump > accepted step > hold; frozen during BOOT
  always_comb begin
    pc_d    = pc_q;
    fault_d = 1'b0;
    if (state_q != ST_BOOT) begin
      if (trap) begin
        pc_d = trap_aligned;
      end else if (jump) begin
        if (misaligned) begin
          pc_d    = trap_aligned;
          fault_d = 1'b1;
        end else begin
          pc_d = target;
        end
      end else if (accept) begin
        pc_d = pc_q + step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_VECTOR;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign misaligned_fault = fault_q;

endmodule
